// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - SHA-1 constants, FSM state type and round helper functions
package sha1_pkg;

   localparam int ROUNDS = 80;

   localparam logic [31:0] K_00_19 = 32'h5A827999;
   localparam logic [31:0] K_20_39 = 32'h6ED9EBA1;
   localparam logic [31:0] K_40_59 = 32'h8F1BBCDC;
   localparam logic [31:0] K_60_79 = 32'hCA62C1D6;

   // Standard initial chaining value, H0 in the top word.
   localparam logic [159:0] SHA1_IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                       32'h10325476, 32'hC3D2E1F0};

   typedef enum logic [1:0] {IDLE, RUN, OUT} state_e;

   function automatic logic [31:0] f_ch(input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] d);
      return (b & c) | (~b & d);
   endfunction

   function automatic logic [31:0] f_parity(input logic [31:0] b, input logic [31:0] c,
                                            input logic [31:0] d);
      return b ^ c ^ d;
   endfunction

   function automatic logic [31:0] f_maj(input logic [31:0] b, input logic [31:0] c,
                                         input logic [31:0] d);
      return (b & c) | (b & d) | (c & d);
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

endpackage

// File: rtl/sha1_step.sv
// rtl/sha1_step.sv - one combinational SHA-1 round
module sha1_step
   import sha1_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] c_i,
   input  logic [31:0] d_i,
   input  logic [31:0] e_i,
   input  logic [31:0] w_i,
   input  logic [6:0]  j_i,
   output logic [31:0] a_o,
   output logic [31:0] b_o,
   output logic [31:0] c_o,
   output logic [31:0] d_o,
   output logic [31:0] e_o
);

   logic [31:0] f;
   logic [31:0] k;

   // Round function and constant follow this round's own index.
   always_comb begin
      f = f_ch(b_i, c_i, d_i);
      k = K_00_19;
      if (j_i >= 7'd60) begin
         f = f_parity(b_i, c_i, d_i);
         k = K_60_79;
      end else if (j_i >= 7'd40) begin
         f = f_maj(b_i, c_i, d_i);
         k = K_40_59;
      end else if (j_i >= 7'd20) begin
         f = f_parity(b_i, c_i, d_i);
         k = K_20_39;
      end
   end

   assign a_o = rotl(a_i, 5) + f + e_i + w_i + k;
   assign b_o = a_i;
   assign c_o = rotl(b_i, 30);
   assign d_o = c_i;
   assign e_o = d_i;

endmodule

// File: rtl/sha1_compress.sv
// rtl/sha1_compress.sv - iterative SHA-1 compression, ROUNDS_PER_CYCLE rounds per clock
module sha1_compress
   import sha1_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_init,
   input  logic [159:0] in_h,
   input  logic [511:0] in_block,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [159:0] out_h
);

   localparam int R = ROUNDS_PER_CYCLE;

   if (!(R == 1 || R == 2 || R == 4 || R == 5 || R == 8 || R == 10 || R == 16)) begin : g_bad_r
      $error("sha1_compress: ROUNDS_PER_CYCLE must be 1, 2, 4, 5, 8, 10 or 16");
   end

   state_e               state_q, state_d;
   logic [159:0]         abcde_q, abcde_d;
   logic [159:0]         h_q, h_d;
   logic [15:0][31:0]    w_q, w_d;
   logic [6:0]           t_q, t_d;
   logic [159:0]         out_h_q, out_h_d;

   logic [159:0]         abcde_nx;
   logic [31:0]          w_shift [16];
   logic                 last_cycle;

   // Window invariant: w_q[i] holds W[t+i], so round t+k always reads w_q[k].
   for (genvar k = 0; k < R; k++) begin : g_round
      logic [159:0] st_in;
      logic [159:0] st_out;
      if (k == 0) begin : g_first
         assign st_in = abcde_q;
      end else begin : g_chain
         assign st_in = g_round[k-1].st_out;
      end
      sha1_step u_step (
         .a_i (st_in[159:128]), .b_i (st_in[127:96]), .c_i (st_in[95:64]),
         .d_i (st_in[63:32]),   .e_i (st_in[31:0]),   .w_i (w_q[k]),
         .j_i (t_q + 7'(k)),
         .a_o (st_out[159:128]), .b_o (st_out[127:96]), .c_o (st_out[95:64]),
         .d_o (st_out[63:32]),   .e_o (st_out[31:0])
      );
   end
   assign abcde_nx = g_round[R-1].st_out;

   // New schedule words W[t+16+i]; later ones may depend on earlier new ones.
   for (genvar i = 0; i < R; i++) begin : g_sched
      logic [31:0] x3, x8, x14;
      logic [31:0] w_new;
      if (i < 3)  begin : g_x3o  assign x3  = w_q[i+13]; end
      else        begin : g_x3n  assign x3  = g_sched[i-3].w_new; end
      if (i < 8)  begin : g_x8o  assign x8  = w_q[i+8]; end
      else        begin : g_x8n  assign x8  = g_sched[i-8].w_new; end
      if (i < 14) begin : g_x14o assign x14 = w_q[i+2]; end
      else        begin : g_x14n assign x14 = g_sched[i-14].w_new; end
      assign w_new = rotl(x3 ^ x8 ^ x14 ^ w_q[i], 1);
   end

   for (genvar i = 0; i < 16; i++) begin : g_win
      if (i + R < 16) begin : g_keep
         assign w_shift[i] = w_q[i+R];
      end else begin : g_fill
         assign w_shift[i] = g_sched[i+R-16].w_new;
      end
   end

   assign last_cycle = (t_q == 7'(ROUNDS - R));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and registered-state output decodes.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: if (last_cycle) state_d = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next-state: load on accept, advance R rounds in RUN, fold digest at the end.
   always_comb begin
      abcde_d = abcde_q;
      h_d     = h_q;
      w_d     = w_q;
      t_d     = t_q;
      out_h_d = out_h_q;
      case (state_q)
         IDLE: if (in_valid) begin
            abcde_d = in_init ? SHA1_IV : in_h;
            h_d     = in_init ? SHA1_IV : in_h;
            for (int i = 0; i < 16; i++) w_d[i] = in_block[511-32*i -: 32];
            t_d     = '0;
         end
         RUN: begin
            abcde_d = abcde_nx;
            for (int i = 0; i < 16; i++) w_d[i] = w_shift[i];
            t_d     = t_q + 7'(R);
            if (last_cycle) begin
               for (int i = 0; i < 5; i++) out_h_d[32*i +: 32] = h_q[32*i +: 32] + abcde_nx[32*i +: 32];
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset discards any block in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         abcde_q <= '0;
         h_q     <= '0;
         w_q     <= '0;
         t_q     <= '0;
         out_h_q <= '0;
      end else begin
         abcde_q <= abcde_d;
         h_q     <= h_d;
         w_q     <= w_d;
         t_q     <= t_d;
         out_h_q <= out_h_d;
      end
   end

   assign out_h = out_h_q;

endmodule

// File: tb/tb_sha1_compress.sv
// tb/tb_sha1_compress.sv - self-checking bench for sha1_compress at R = 1, 4 and 16
module tb_sha1_compress;

   localparam logic [159:0] IV       = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
   localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [159:0] DIG_ABC  = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [511:0] BLK_NULL = {32'h80000000, 480'h0};
   localparam logic [159:0] DIG_NULL = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
   localparam logic [447:0] MSG56    = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
   localparam logic [511:0] BLK_TWO1 = {MSG56, 32'h80000000, 32'h0};
   localparam logic [511:0] BLK_TWO2 = {480'h0, 32'h000001C0};
   localparam logic [159:0] DIG_TWO  = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   in_valid, in_ready, out_valid, out_ready;
   logic         in_init;
   logic [159:0] in_h;
   logic [511:0] in_block;
   logic [159:0] out_h [3];

   int vectors = 0;
   int miscompares = 0;
   int lats [3] = '{80, 20, 5};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int RV = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
      sha1_compress #(.ROUNDS_PER_CYCLE(RV)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_init   (in_init),
         .in_h      (in_h),
         .in_block  (in_block),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_h     (out_h[g])
      );
   end

   function automatic logic [31:0] rol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Reference: full 80-word expansion, then 80 rounds, then feed-forward.
   function automatic logic [159:0] ref_sha1(input logic [159:0] h, input logic [511:0] blk);
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, tmp;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 80; i++) w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
      {a, b, c, d, e} = h;
      for (int i = 0; i < 80; i++) begin
         if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
         else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
         else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
         else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
         tmp = rol(a, 5) + f + e + k + w[i];
         e = d; d = c; c = rol(b, 30); b = a; a = tmp;
      end
      return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
   endfunction

   function automatic logic [511:0] rand_blk();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [159:0] rand_h();
      logic [159:0] r;
      for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accept edge.
   task automatic offer(input int i, input logic init, input logic [159:0] h, input logic [511:0] blk);
      int n = 0;
      in_init = init; in_h = h; in_block = blk; in_valid[i] = 1'b1;
      while (!in_ready[i] && n < 300) begin @(negedge clk); n++; end
      check($sformatf("offer%0d_ready", i), 160'(in_ready[i]), 160'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid[i] = 1'b0;
      in_init = 1'($urandom()); in_h = rand_h(); in_block = rand_blk();
   endtask

   task automatic collect(input int i, input logic [159:0] exp, input string tag);
      int n = 0;
      while (!out_valid[i] && n < 300) begin @(negedge clk); n++; end
      check($sformatf("%s_latency", tag), 160'(n), 160'(lats[i]));
      check($sformatf("%s_digest", tag), out_h[i], exp);
      check($sformatf("%s_busy", tag), 160'(in_ready[i]), 160'd0);
      out_ready[i] = 1'b1;
      @(negedge clk);
      out_ready[i] = 1'b0;
      check($sformatf("%s_release", tag), 160'({out_valid[i], in_ready[i]}), 160'b01);
   endtask

   task automatic back_to_back(input int i, input int nblk);
      logic [159:0] q [$];
      logic [159:0] exp;
      logic [511:0] blk;
      int accepts = 0, outs = 0, last = 0;
      bit pend = 0;
      blk = rand_blk();
      in_init = 1'b1; in_block = blk; in_valid[i] = 1'b1; out_ready[i] = 1'b1;
      for (int c = 0; c < nblk * (lats[i] + 2) + 10; c++) begin
         if (out_valid[i]) begin
            exp = (q.size() > 0) ? q.pop_front() : '0;
            check($sformatf("b2b%0d_digest", i), out_h[i], exp);
            outs++;
         end
         if (in_ready[i] && in_valid[i]) begin
            if (accepts > 0) check($sformatf("b2b%0d_spacing", i), 160'(c - last), 160'(lats[i] + 2));
            last = c;
            q.push_back(ref_sha1(IV, blk));
            accepts++;
            pend = 1;
         end
         @(negedge clk);
         if (pend) begin
            pend = 0;
            if (accepts == nblk) in_valid[i] = 1'b0;
            else begin blk = rand_blk(); in_block = blk; end
         end
      end
      out_ready[i] = 1'b0;
      check($sformatf("b2b%0d_accepts", i), 160'(accepts), 160'(nblk));
      check($sformatf("b2b%0d_outputs", i), 160'(outs), 160'(nblk));
   endtask

   initial begin
      logic [159:0] h1, hr, ha, hb;
      logic [511:0] blk, ba, bb;
      logic         init;
      int           n;

      rst_n = 1'b0; in_valid = '0; out_ready = '0;
      in_init = 1'b0; in_h = '0; in_block = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset%0d_flags", i), 160'({in_ready[i], out_valid[i]}), 160'b10);
         check($sformatf("reset%0d_out_h", i), out_h[i], '0);
      end

      // Known answers; in_h is random and must be ignored when in_init is set.
      offer(0, 1'b1, rand_h(), BLK_ABC);  collect(0, DIG_ABC, "abc_r1");
      offer(1, 1'b1, rand_h(), BLK_NULL); collect(1, DIG_NULL, "empty_r4");
      offer(2, 1'b1, rand_h(), BLK_NULL); collect(2, DIG_NULL, "empty_r16");

      // Two-block chaining through in_h.
      h1 = ref_sha1(IV, BLK_TWO1);
      for (int i = 0; i < 3; i++) begin
         offer(i, 1'b1, '0, BLK_TWO1); collect(i, h1, $sformatf("two_a_%0d", i));
         offer(i, 1'b0, h1, BLK_TWO2); collect(i, DIG_TWO, $sformatf("two_b_%0d", i));
      end

      // Random blocks and chaining values.
      for (int i = 0; i < 3; i++) begin
         for (int r = 0; r < 4; r++) begin
            init = 1'($urandom());
            hr   = rand_h();
            blk  = rand_blk();
            offer(i, init, hr, blk);
            collect(i, ref_sha1(init ? IV : hr, blk), $sformatf("rand%0d_%0d", i, r));
         end
      end

      // Backpressure on R=4 with a second block offered during OUT.
      ba = rand_blk(); bb = rand_blk();
      ha = ref_sha1(IV, ba); hb = ref_sha1(IV, bb);
      offer(1, 1'b1, '0, ba);
      n = 0;
      while (!out_valid[1] && n < 300) begin @(negedge clk); n++; end
      check("bp_latency", 160'(n), 160'd20);
      in_valid[1] = 1'b1; in_init = 1'b1; in_block = bb;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("bp_valid", 160'(out_valid[1]), 160'd1);
         check("bp_out_h", out_h[1], ha);
         check("bp_in_ready", 160'(in_ready[1]), 160'd0);
      end
      out_ready[1] = 1'b1;
      @(negedge clk);
      out_ready[1] = 1'b0;
      check("bp_handshake", 160'({out_valid[1], in_ready[1]}), 160'b01);
      @(posedge clk);
      @(negedge clk);
      in_valid[1] = 1'b0;
      collect(1, hb, "bp_next");

      // Reset mid-RUN on R=1 while R=16 holds a digest in OUT.
      offer(2, 1'b1, '0, BLK_ABC);
      repeat (5) @(negedge clk);
      check("pre_rst_hold", out_h[2], DIG_ABC);
      offer(0, 1'b1, '0, BLK_ABC);
      repeat (37) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_flags", 160'({in_ready, out_valid}), 160'b111_000);
      check("rst_out_h2", out_h[2], '0);
      check("rst_out_h0", out_h[0], '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_flags", 160'({in_ready, out_valid}), 160'b111_000);
      offer(0, 1'b1, rand_h(), BLK_ABC); collect(0, DIG_ABC, "abc_after_rst");

      // Back-to-back with in_valid and out_ready held high.
      for (int i = 0; i < 3; i++) back_to_back(i, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
